// File: rtl/controle_elevador.sv
// -----------------------------------------------------------------------------
// controle_elevador
//   Sequencing controller for a 16-floor elevator. Floor calls are latched
//   into a pending register; a travel/door state machine serves them in SCAN
//   order (keep going while requests remain ahead, then reverse).
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   botao_i         floor call buttons, bit i = floor i (level or pulse)
//   andar_o         current floor (registered)
//   pedidos_o       latched pending requests (registered)
//   subindo_o       cabin moving up
//   descendo_o      cabin moving down
//   porta_aberta_o  door open
//   estado_o        state code: PARADO=0, SUBINDO=1, DESCENDO=2, PORTA=3
// -----------------------------------------------------------------------------
module controle_elevador #(
    parameter int T_VIAGEM = 8,
    parameter int T_PORTA  = 4,
    parameter int W_TMR    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] botao_i,
    output logic [3:0]  andar_o,
    output logic [15:0] pedidos_o,
    output logic        subindo_o,
    output logic        descendo_o,
    output logic        porta_aberta_o,
    output logic [1:0]  estado_o
);

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        SUBINDO  = 2'd1,
        DESCENDO = 2'd2,
        PORTA    = 2'd3
    } estado_t;

    localparam logic [W_TMR-1:0] TMR_VIAGEM = W_TMR'(T_VIAGEM - 1);
    localparam logic [W_TMR-1:0] TMR_PORTA  = W_TMR'(T_PORTA - 1);

    estado_t          estado_q, estado_d;
    logic             dir_sobe_q, dir_sobe_d;
    logic [3:0]       andar_q, andar_d;
    logic [15:0]      pedidos_q, pedidos_d;
    logic [W_TMR-1:0] timer_q, timer_d;

    // ou_acima[i]  = any request at floor >= i
    // ou_abaixo[i] = any request at floor <= i
    logic [15:0] ou_acima;
    logic [15:0] ou_abaixo;

    logic [3:0]  andar_p1, andar_p2, andar_m1, andar_m2;
    logic        acima, abaixo, aqui;
    logic        alem_sobe, alem_desce;
    logic [15:0] limpa;

    always_comb begin
        ou_acima  = '0;
        ou_abaixo = '0;
        for (int i = 0; i < 16; i++) begin
            ou_acima[i]  = |(pedidos_q & (16'hFFFF << i));
            ou_abaixo[i] = |(pedidos_q & (16'hFFFF >> (15 - i)));
        end
    end

    // Neighbour floors wrap in 4 bits; every use below is guarded so a
    // wrapped index is never consulted.
    assign andar_p1 = andar_q + 4'd1;
    assign andar_p2 = andar_q + 4'd2;
    assign andar_m1 = andar_q - 4'd1;
    assign andar_m2 = andar_q - 4'd2;

    assign acima  = (andar_q != 4'd15) && ou_acima[andar_p1];
    assign abaixo = (andar_q != 4'd0)  && ou_abaixo[andar_m1];
    assign aqui   = pedidos_q[andar_q];

    // Requests strictly beyond the floor being arrived at, in travel direction.
    assign alem_sobe  = (andar_p1 != 4'd15) && ou_acima[andar_p2];
    assign alem_desce = (andar_m1 != 4'd0)  && ou_abaixo[andar_m2];

    always_comb begin
        estado_d   = estado_q;
        dir_sobe_d = dir_sobe_q;
        andar_d    = andar_q;
        timer_d    = timer_q;

        case (estado_q)
            PARADO: begin
                if (aqui) begin
                    estado_d = PORTA;
                    timer_d  = TMR_PORTA;
                end else if (dir_sobe_q && acima) begin
                    estado_d = SUBINDO;
                    timer_d  = TMR_VIAGEM;
                end else if (!dir_sobe_q && abaixo) begin
                    estado_d = DESCENDO;
                    timer_d  = TMR_VIAGEM;
                end else if (acima) begin
                    estado_d   = SUBINDO;
                    dir_sobe_d = 1'b1;
                    timer_d    = TMR_VIAGEM;
                end else if (abaixo) begin
                    estado_d   = DESCENDO;
                    dir_sobe_d = 1'b0;
                    timer_d    = TMR_VIAGEM;
                end
            end

            SUBINDO: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    andar_d = andar_p1;
                    // A call raised in the arrival cycle is still served here.
                    if (pedidos_q[andar_p1] || botao_i[andar_p1]) begin
                        estado_d = PORTA;
                        timer_d  = TMR_PORTA;
                    end else if (alem_sobe) begin
                        timer_d = TMR_VIAGEM;
                    end else begin
                        estado_d = PARADO;
                    end
                end
            end

            DESCENDO: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    andar_d = andar_m1;
                    if (pedidos_q[andar_m1] || botao_i[andar_m1]) begin
                        estado_d = PORTA;
                        timer_d  = TMR_PORTA;
                    end else if (alem_desce) begin
                        timer_d = TMR_VIAGEM;
                    end else begin
                        estado_d = PARADO;
                    end
                end
            end

            PORTA: begin
                if (botao_i[andar_q]) begin
                    timer_d = TMR_PORTA;
                end else if (timer_q == '0) begin
                    estado_d = PARADO;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            default: estado_d = PARADO;
        endcase

        // Whenever the next state has the door open, the floor it is open at
        // is being served, so its request bit is dropped (covers both the
        // arrival edge and every cycle spent in PORTA).
        limpa     = (estado_d == PORTA) ? (16'd1 << andar_d) : 16'd0;
        pedidos_d = (pedidos_q | botao_i) & ~limpa;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= PARADO;
            dir_sobe_q <= 1'b1;
            andar_q    <= 4'd0;
            pedidos_q  <= 16'd0;
            timer_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            dir_sobe_q <= dir_sobe_d;
            andar_q    <= andar_d;
            pedidos_q  <= pedidos_d;
            timer_q    <= timer_d;
        end
    end

    assign andar_o        = andar_q;
    assign pedidos_o      = pedidos_q;
    assign estado_o       = estado_q;
    assign subindo_o      = (estado_q == SUBINDO);
    assign descendo_o     = (estado_q == DESCENDO);
    assign porta_aberta_o = (estado_q == PORTA);

endmodule

// File: tb/tb_controle_elevador.sv
// -----------------------------------------------------------------------------
// tb_controle_elevador
//   Self-checking bench for controle_elevador: a behavioural elevator model
//   (floor number, per-floor request flags, countdown) checked every cycle,
//   directed scenarios with literal expectations, then random button traffic.
// -----------------------------------------------------------------------------
module tb_controle_elevador;

    localparam int TV = 8;
    localparam int TP = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] botao = 16'd0;
    logic [3:0]  andar_o;
    logic [15:0] pedidos_o;
    logic        subindo_o, descendo_o, porta_aberta_o;
    logic [1:0]  estado_o;

    always #5 clk = ~clk;

    controle_elevador #(.T_VIAGEM(TV), .T_PORTA(TP), .W_TMR(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .botao_i       (botao),
        .andar_o       (andar_o),
        .pedidos_o     (pedidos_o),
        .subindo_o     (subindo_o),
        .descendo_o    (descendo_o),
        .porta_aberta_o(porta_aberta_o),
        .estado_o      (estado_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    // ---------------- behavioural model ----------------
    // m_state: 0 idle, 1 going up, 2 going down, 3 door open
    int m_floor = 0;
    int m_state = 0;
    int m_tmr   = 0;
    bit m_up    = 1;
    bit m_pend[16];

    function automatic bit req_range(input int lo, input int hi);
        for (int j = lo; j <= hi; j++)
            if (j >= 0 && j <= 15 && m_pend[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] pend_vec();
        logic [15:0] v;
        v = '0;
        for (int j = 0; j < 16; j++) v[j] = m_pend[j];
        return v;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_state = 0; m_tmr = 0; m_up = 1;
        for (int j = 0; j < 16; j++) m_pend[j] = 0;
    endtask

    task automatic model_step(input logic [15:0] b);
        int ns, nf, nt;
        bit nu;
        ns = m_state; nf = m_floor; nt = m_tmr; nu = m_up;
        case (m_state)
            0: begin
                if (m_pend[m_floor]) begin ns = 3; nt = TP - 1; end
                else if (m_up && req_range(m_floor + 1, 15)) begin ns = 1; nt = TV - 1; end
                else if (!m_up && req_range(0, m_floor - 1)) begin ns = 2; nt = TV - 1; end
                else if (req_range(m_floor + 1, 15)) begin ns = 1; nt = TV - 1; nu = 1; end
                else if (req_range(0, m_floor - 1)) begin ns = 2; nt = TV - 1; nu = 0; end
            end
            1, 2: begin
                if (m_tmr > 0) nt = m_tmr - 1;
                else begin
                    nf = (m_state == 1) ? m_floor + 1 : m_floor - 1;
                    if (m_pend[nf] || b[nf]) begin ns = 3; nt = TP - 1; end
                    else if ((m_state == 1) ? req_range(nf + 1, 15) : req_range(0, nf - 1)) nt = TV - 1;
                    else ns = 0;
                end
            end
            default: begin
                if (b[m_floor]) nt = TP - 1;
                else if (m_tmr == 0) ns = 0;
                else nt = m_tmr - 1;
            end
        endcase
        for (int j = 0; j < 16; j++) m_pend[j] = m_pend[j] | b[j];
        if (ns == 3) m_pend[nf] = 0;
        m_state = ns; m_floor = nf; m_tmr = nt; m_up = nu;
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step(botao);
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (andar_o !== 4'(m_floor) || pedidos_o !== pend_vec() ||
                estado_o !== 2'(m_state) || subindo_o !== (m_state == 1) ||
                descendo_o !== (m_state == 2) || porta_aberta_o !== (m_state == 3)) begin
                n_err++;
                $display("FAIL model_cycle t=%0t: got andar=%0d pedidos=%h estado=%0d sub/des/porta=%b%b%b, want andar=%0d pedidos=%h estado=%0d",
                         $time, andar_o, pedidos_o, estado_o, subindo_o, descendo_o, porta_aberta_o,
                         m_floor, pend_vec(), m_state);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic wait_at(input string nm, input int fl, input int st, input int budget);
        bit ok;
        ok = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            ok = (int'(andar_o) == fl) && (int'(estado_o) == st);
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got andar=%0d estado=%0d after %0d cycles, want andar=%0d estado=%0d",
                     nm, andar_o, estado_o, budget, fl, st);
        end
    endtask

    task automatic press(input int fl);
        botao = 16'd1 << fl;
        @(negedge clk);
        botao = 16'd0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios and random traffic ----------------
    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("reset_andar", andar_o, 0);
        chk("reset_pedidos", pedidos_o, 0);
        chk("reset_estado", estado_o, 0);
        chk("reset_flags", {subindo_o, descendo_o, porta_aberta_o}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Idle at 0, single call for floor 3 (edges counted from the pulse)
        botao = 16'h0008;
        @(negedge clk);                       // edge 1
        botao = 16'd0;
        chk("tp1_latch", pedidos_o, 16'h0008);
        chk("tp1_idle_edge1", estado_o, 0);
        @(negedge clk);                       // edge 2
        chk("tp1_up_edge2", estado_o, 1);
        chk("tp1_subindo", subindo_o, 1);
        repeat (7) @(negedge clk);            // edge 9
        chk("tp1_floor0_edge9", andar_o, 0);
        @(negedge clk);                       // edge 10
        chk("tp1_floor1_edge10", andar_o, 1);
        repeat (8) @(negedge clk);            // edge 18
        chk("tp1_floor2_edge18", andar_o, 2);
        repeat (7) @(negedge clk);            // edge 25
        chk("tp1_moving_edge25", estado_o, 1);
        @(negedge clk);                       // edge 26
        chk("tp1_floor3_edge26", andar_o, 3);
        chk("tp1_door_edge26", porta_aberta_o, 1);
        chk("tp1_cleared", pedidos_o, 0);
        repeat (3) @(negedge clk);            // edge 29
        chk("tp1_door_edge29", estado_o, 3);
        @(negedge clk);                       // edge 30
        chk("tp1_idle_edge30", estado_o, 0);

        // Going up through 5 with calls at 8 and 2: 8 first, then reverse
        botao = (16'd1 << 5) | (16'd1 << 8);
        @(negedge clk);
        botao = 16'd0;
        wait_at("tp2_door5", 5, 3, 40);
        press(2);
        wait_at("tp2_door8", 8, 3, 60);
        chk("tp2_pending_2", pedidos_o, 16'h0004);
        wait_at("tp2_reverse_down", 8, 2, 20);
        wait_at("tp2_door2", 2, 3, 80);
        wait_at("tp2_idle2", 2, 0, 20);

        // From 0 to 6, extra call at 4 while passing floor 3
        do_reset();
        press(6);
        wait_at("tp3_at3", 3, 1, 40);
        press(4);
        wait_at("tp3_stop4", 4, 3, 20);
        wait_at("tp3_door6", 6, 3, 40);
        wait_at("tp3_idle6", 6, 0, 20);
        chk("tp3_pedidos_empty", pedidos_o, 0);

        // Door reopen held at floor 2
        press(2);
        wait_at("tp4_door2", 2, 3, 60);
        botao = 16'h0004;
        repeat (3) @(negedge clk);
        botao = 16'd0;
        chk("tp4_open_after_hold", estado_o, 3);
        chk("tp4_not_latched", pedidos_o[2], 0);
        repeat (3) @(negedge clk);
        chk("tp4_open_last", estado_o, 3);
        @(negedge clk);
        chk("tp4_closed", estado_o, 0);

        // Reset mid-travel towards 9
        press(9);
        wait_at("tp5_at4", 4, 1, 40);
        #2 rst_n = 1'b0;
        #1;
        chk("tp5_rst_andar", andar_o, 0);
        chk("tp5_rst_pedidos", pedidos_o, 0);
        chk("tp5_rst_estado", estado_o, 0);
        chk("tp5_rst_flags", {subindo_o, descendo_o, porta_aberta_o}, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("tp5_stays_idle", estado_o, 0);
        chk("tp5_stays_floor0", andar_o, 0);

        // Top and bottom floors
        press(15);
        wait_at("tp6_door15", 15, 3, 15 * TV + 20);
        wait_at("tp6_idle15", 15, 0, 20);
        botao = 16'h8000;
        @(negedge clk);
        botao = 16'd0;
        @(negedge clk);
        chk("tp6_top_door", estado_o, 3);
        wait_at("tp6_idle15b", 15, 0, 20);
        do_reset();
        botao = 16'h0001;
        @(negedge clk);
        botao = 16'd0;
        @(negedge clk);
        chk("tp6_bottom_door", estado_o, 3);
        wait_at("tp6_idle0", 0, 0, 20);

        // Random traffic, with occasional multi-button bursts and resets
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 799) == 0) begin
                botao = 16'd0;
                do_reset();
            end else if ($urandom_range(0, 39) == 0) begin
                botao = 16'($urandom) & 16'($urandom) & 16'($urandom);
                @(negedge clk);
            end else if ($urandom_range(0, 7) == 0) begin
                botao = 16'd1 << $urandom_range(0, 15);
                @(negedge clk);
            end else begin
                botao = 16'd0;
                @(negedge clk);
            end
        end
        botao = 16'd0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/controle_elevador.md
Name: controle_elevador

Overview:
- Sequencing controller for the 16-floor elevator.
- Latches floor-button requests into a pending register and tracks the current floor.
- Derives "request above" and "request below" from the pending register, using the same prefix-OR scheme as the descent detector.
- Steps a travel/door state machine that serves requests in SCAN order: keep the current direction while requests remain ahead, then reverse.

Parameters:
- T_VIAGEM, 8, clock cycles to travel one floor (≥2).
- T_PORTA, 4, clock cycles the door stays open (≥2).
- W_TMR, 4, timer width; must hold max(T_VIAGEM, T_PORTA)-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- botao  in  16  floor call buttons; level or pulse, bit i = floor i.
- andar  out  4  current floor, registered.
- pedidos  out  16  latched pending requests, registered.
- subindo  out  1  cabin moving up (state SUBINDO).
- descendo  out  1  cabin moving down (state DESCENDO).
- porta_aberta  out  1  door open (state PORTA).
- estado  out  2  state code: PARADO=0, SUBINDO=1, DESCENDO=2, PORTA=3.

Behaviour:
- Reset (async assert, sync release):
  - andar=0, pedidos=0, estado=PARADO, dir_sobe=1, timer=0.
  - All outputs low except as implied by estado=0.
  - Reset during travel or with the door open abandons the operation; no request survives.
- Request latch, every cycle:
  - pedidos_next = (pedidos | botao) & ~limpa.
  - limpa = one-hot(andar) while in PORTA, or on the edge entering PORTA at the arriving floor.
  - In PORTA, a button at the current floor is never latched.
- Internal combinational flags from pedidos and andar:
  - acima = any pedidos[j], j > andar.
  - abaixo = any pedidos[j], j < andar.
  - aqui = pedidos[andar].
  - Floor 15 gives acima=0; floor 0 gives abaixo=0.
- PARADO, evaluated in priority order:
  - aqui → PORTA, timer = T_PORTA-1.
  - Else dir_sobe & acima → SUBINDO.
  - Else !dir_sobe & abaixo → DESCENDO.
  - Else acima → SUBINDO, dir_sobe=1.
  - Else abaixo → DESCENDO, dir_sobe=0.
  - Else stay in PARADO.
  - Entering SUBINDO or DESCENDO loads timer = T_VIAGEM-1.
- SUBINDO / DESCENDO:
  - Timer decrements each cycle.
  - On the edge where timer==0, andar becomes andar±1 (next floor n).
  - Same edge, if pedidos[n] or botao[n] → PORTA, timer = T_PORTA-1, bit n cleared.
  - Else, if requests remain beyond n in the same direction → stay, timer = T_VIAGEM-1.
  - Else → PARADO.
  - andar never wraps: SUBINDO is never entered at 15, DESCENDO never at 0.
- PORTA:
  - porta_aberta=1; timer decrements.
  - botao[andar]=1 reloads timer = T_PORTA-1 (door-reopen).
  - Timer==0 and no reopen → PARADO.
  - Requests for other floors latch normally while the door is open.
- Latency:
  - botao[i] pulse at cycle t → pedidos[i]=1 after edge t+1.
  - From PARADO, the state changes on edge t+2.
  - Door open time is exactly T_PORTA cycles without reopen.
  - One floor takes exactly T_VIAGEM cycles.
- Simultaneous events:
  - A request for the floor being arrived at, raised in the arrival cycle, is served at that arrival.
  - A request behind the cabin waits for reversal.
  - Requests above and below while idle at dir_sobe=1 → up first.
- Outputs subindo, descendo, porta_aberta and estado are decoded from the state register only; no glitches from botao.

Test Plan:
- Idle at 0, pulse botao[3] at cycle 0:
  - SUBINDO from edge 2; andar goes 1, 2, 3 at edges 10, 18, 26.
  - PORTA at edge 26 with pedidos[3]=0; porta_aberta high 4 cycles; PARADO at edge 30.
- At floor 5 going up, pedidos = floors 8 and 2:
  - Serves 8 first (andar 6, 7, 8), door opens, returns PARADO.
  - Then DESCENDO to 2; dir_sobe=0 after reversal.
- Moving up 0→6; assert botao[4] while andar=3:
  - Cabin stops at 4 (PORTA), then continues to 6; pedidos ends at 0.
- Door open at floor 2; hold botao[2] for 3 cycles mid-door:
  - Door stays open T_PORTA cycles after the last press; pedidos[2] stays 0.
- Travel toward 9; assert rst_n=0 at andar=4:
  - Outputs immediately andar=0, pedidos=0, estado=0, all flags 0.
  - After release with no buttons, stays PARADO.
- At floor 15 with only botao[15]: PORTA, never SUBINDO. At floor 0 with only botao[0]: PORTA, never DESCENDO.
